mc_cpu_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit CPU core. It accepts 16-bit instructions through a valid/ready handshake and steps each one through a FETCH / EXEC / WB state machine. It supports register and immediate operand modes, a wider ALU with zero/carry flags, illegal-opcode detection, a HALT state and a retire counter. It sits between the instruction source (testbench or future fetch unit) and the debug/observation logic.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/alu_ext.sv | 58 +++++
 rtl/mc_cpu_core.sv | 121 ++++++++++++
 tb/tb_mc_cpu_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types, instruction field positions and opcode helpers for the
// multi-cycle CPU core and its ALU.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_SUB  = 6'h01,
    OP_AND  = 6'h02,
    OP_OR   = 6'h03,
    OP_XOR  = 6'h04,
    OP_SHL  = 6'h05,
    OP_SHR  = 6'h06,
    OP_ADDI = 6'h10,
    OP_SUBI = 6'h11,
    OP_ANDI = 6'h12,
    OP_LI   = 6'h13,
    OP_HALT = 6'h3F
  } opcode_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 7;
  localparam int RT_HI  = 6;
  localparam int RT_LO  = 4;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 1;
  localparam int IRD_HI = 9;
  localparam int IRD_LO = 7;
  localparam int IMM_W  = 7;

  function automatic logic is_itype(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_LI};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op <= 6'h06) || is_itype(op) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/alu_ext.sv
// Combinational ALU: arithmetic, logic and shifts with zero/carry outputs.
// Carry is carry-out for add, borrow for subtract, last bit out for shifts.
module alu_ext
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  localparam int SHW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SHW-1:0]  sh;
  logic [DATA_W:0] wide;

  assign sh = b[SHW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    wide   = '0;
    case (op)
      OP_ADD, OP_ADDI: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB, OP_SUBI: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND, OP_ANDI: result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      // One guard bit on the outgoing side captures the last bit shifted out.
      OP_SHL: begin
        wide   = {1'b0, a} << sh;
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SHR: begin
        wide   = {a, 1'b0} >> sh;
        result = wide[DATA_W:1];
        carry  = wide[0];
      end
      OP_LI:   result = b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/EXEC/WB/HALT sequencing, inline register file,
// registered result and flags, and a wrapping retire counter.
module mc_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              retire_valid,
  output logic [DATA_W-1:0] result_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: an instruction is accepted on a rising edge where
  // instr_valid && instr_ready; instr_ready is high only in FETCH.

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [5:0]        opc;
  logic              itype, legal, alu_op;
  logic [2:0]        src_a_idx, src_b_idx, dst_idx;
  logic [DATA_W-1:0] rf_a, rf_b, imm, op_b, alu_res;
  logic              alu_c, alu_z;

  assign opc       = ir[OPC_HI:OPC_LO];
  assign itype     = is_itype(opc);
  assign legal     = is_legal(opc);
  assign alu_op    = legal && (opc != OP_HALT);
  assign src_a_idx = itype ? ir[IRD_HI:IRD_LO] : ir[RS_HI:RS_LO];
  assign src_b_idx = ir[RT_HI:RT_LO];
  assign dst_idx   = itype ? ir[IRD_HI:IRD_LO] : ir[RD_HI:RD_LO];

  // Indices beyond NUM_REGS match no entry and therefore read as zero.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_a_idx == i[2:0]) rf_a = regs[i];
      if (src_b_idx == i[2:0]) rf_b = regs[i];
    end
  end

  always_comb begin
    imm = '0;
    for (int i = 0; i < IMM_W && i < DATA_W; i++) imm[i] = ir[i];
  end

  assign op_b = itype ? imm : rf_b;

  alu_ext #(.DATA_W(DATA_W)) u_alu (
    .a      (rf_a),
    .b      (op_b),
    .op     (opc),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (instr_valid) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WB;
      ST_WB:    state_nxt = (opc == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  assign instr_ready  = (state == ST_FETCH);
  assign retire_valid = (state == ST_WB);
  assign illegal      = retire_valid && !legal;
  assign halted       = (state == ST_HALT);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      ir         <= '0;
      result_out <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      retire_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid) ir <= instr;
      // Illegal and HALT keep the flags and report a zero result.
      if (state == ST_EXEC) begin
        if (alu_op) begin
          result_out <= alu_res;
          flag_z     <= alu_z;
          flag_c     <= alu_c;
        end else begin
          result_out <= '0;
        end
      end
      if (state == ST_WB) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        if (alu_op) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (dst_idx == i[2:0]) regs[i] <= result_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: an 8-bit default instance and a 16-bit,
// 4-register, 4-bit-counter instance, each driven by a vector table.
module tb_mc_cpu_core;

  typedef struct {
    logic [15:0] ins;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        ill;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] instr_a, instr_b;
  logic        valid_a, valid_b;

  logic        rdy_a, ret_a, z_a, c_a, ill_a, hlt_a;
  logic [7:0]  res_a;
  logic [15:0] cnt_a;
  logic [1:0]  dbg_a;
  logic        rdy_b, ret_b, z_b, c_b, ill_b, hlt_b;
  logic [15:0] res_b;
  logic [3:0]  cnt_b;
  logic [1:0]  dbg_b;

  mc_cpu_core dut_a (
    .clk(clk), .rst_n(rst_a), .instr(instr_a), .instr_valid(valid_a),
    .instr_ready(rdy_a), .retire_valid(ret_a), .result_out(res_a),
    .flag_z(z_a), .flag_c(c_a), .illegal(ill_a), .halted(hlt_a),
    .retire_cnt(cnt_a), .dbg_state(dbg_a)
  );

  mc_cpu_core #(.DATA_W(16), .NUM_REGS(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .instr(instr_b), .instr_valid(valid_b),
    .instr_ready(rdy_b), .retire_valid(ret_b), .result_out(res_b),
    .flag_z(z_b), .flag_c(c_b), .illegal(ill_b), .halted(hlt_b),
    .retire_cnt(cnt_b), .dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt [2] = '{0, 0};

  logic        s_rdy, s_ret, s_z, s_c, s_ill, s_hlt;
  logic [31:0] s_res, s_cnt;
  logic [1:0]  s_dbg;
  logic [31:0] g_res;
  logic        g_z, g_c, g_ill;

  vec_t va[$];
  vec_t vb[$];

  function automatic logic [15:0] r_ins(input logic [5:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 1'b0};
  endfunction

  function automatic logic [15:0] i_ins(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [6:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap(input bit sel);
    if (sel) begin
      s_rdy = rdy_b; s_ret = ret_b; s_z = z_b; s_c = c_b; s_ill = ill_b;
      s_hlt = hlt_b; s_res = {16'h0, res_b}; s_cnt = {28'h0, cnt_b}; s_dbg = dbg_b;
    end else begin
      s_rdy = rdy_a; s_ret = ret_a; s_z = z_a; s_c = c_a; s_ill = ill_a;
      s_hlt = hlt_a; s_res = {24'h0, res_a}; s_cnt = {16'h0, cnt_a}; s_dbg = dbg_a;
    end
  endtask

  task automatic drive(input bit sel, input logic [15:0] ins, input logic v);
    if (sel) begin instr_b = ins; valid_b = v; end
    else     begin instr_a = ins; valid_a = v; end
  endtask

  // driver: issue one instruction and follow it through EXEC, WB and the next cycle
  task automatic issue(input bit sel, input logic [15:0] ins, input bit exp_halt, input string tag);
    int n;
    logic [31:0] mask;
    mask = sel ? 32'hF : 32'hFFFF;
    n = 0;
    do begin
      @(negedge clk); snap(sel); n++;
    end while (!s_rdy && n < 20);
    chk({tag, " accept_ready"}, {31'h0, s_rdy}, 32'h1);
    drive(sel, ins, 1'b1);
    @(posedge clk); #1;
    drive(sel, 16'($urandom_range(0, 65535)), 1'b1);
    @(negedge clk); snap(sel);
    chk({tag, " exec_cycle"}, {28'h0, s_rdy, s_ret, s_dbg}, {28'h0, 2'b00, 2'd1});
    @(negedge clk); snap(sel);
    chk({tag, " wb_cycle"}, {28'h0, s_rdy, s_ret, s_dbg}, {28'h0, 2'b01, 2'd2});
    g_res = s_res; g_z = s_z; g_c = s_c; g_ill = s_ill;
    drive(sel, 16'h0, 1'b0);
    exp_cnt[sel]++;
    @(negedge clk); snap(sel);
    chk({tag, " after_wb"}, {29'h0, s_rdy, s_hlt, s_ret}, {29'h0, !exp_halt, exp_halt, 1'b0});
    chk({tag, " retire_cnt"}, s_cnt, 32'(exp_cnt[sel]) & mask);
  endtask

  task automatic run_table(input bit sel, input vec_t tbl[$]);
    string tag;
    foreach (tbl[i]) begin
      tag = $sformatf("%s[%0d]", sel ? "vb" : "va", i);
      issue(sel, tbl[i].ins, 1'b0, tag);
      chk({tag, " result"}, g_res, tbl[i].res);
      chk({tag, " z_c_ill"}, {29'h0, g_z, g_c, g_ill}, {29'h0, tbl[i].z, tbl[i].c, tbl[i].ill});
    end
  endtask

  task automatic chk_reset_state(input bit sel, input string tag);
    @(negedge clk); snap(sel);
    chk({tag, " ctrl"}, {26'h0, s_rdy, s_ret, s_ill, s_hlt, s_dbg}, {26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    chk({tag, " flags"}, {30'h0, s_z, s_c}, 32'h0);
    chk({tag, " result"}, s_res, 32'h0);
    chk({tag, " cnt"}, s_cnt, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bad;

    va = '{
      '{i_ins(6'h13, 3'd2, 7'd5),        32'h05, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd3, 7'd7),        32'h07, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h00, 3'd2, 3'd3, 3'd1),  32'h0C, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd1, 7'h7F),       32'h7F, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd1, 7'h7F),       32'hFE, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd1, 7'h7F),       32'h7D, 1'b0, 1'b1, 1'b0},
      '{i_ins(6'h10, 3'd1, 7'h05),       32'h82, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h01, 3'd2, 3'd2, 3'd4),  32'h00, 1'b1, 1'b0, 1'b0},
      '{r_ins(6'h01, 3'd2, 3'd3, 3'd5),  32'hFE, 1'b0, 1'b1, 1'b0},
      '{i_ins(6'h2A, 3'd2, 7'h7F),       32'h00, 1'b0, 1'b1, 1'b1},
      '{i_ins(6'h10, 3'd2, 7'd0),        32'h05, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h02, 3'd2, 3'd3, 3'd6),  32'h05, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h03, 3'd2, 3'd3, 3'd6),  32'h07, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h04, 3'd2, 3'd3, 3'd6),  32'h02, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd7, 7'd1),        32'h01, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h05, 3'd1, 3'd7, 3'd6),  32'h04, 1'b0, 1'b1, 1'b0},
      '{r_ins(6'h06, 3'd1, 3'd7, 3'd6),  32'h41, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h06, 3'd2, 3'd7, 3'd6),  32'h02, 1'b0, 1'b1, 1'b0},
      '{r_ins(6'h05, 3'd2, 3'd0, 3'd6),  32'h05, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd7, 7'd9),        32'h09, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h05, 3'd2, 3'd7, 3'd6),  32'h0A, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h11, 3'd3, 7'd7),        32'h00, 1'b1, 1'b0, 1'b0},
      '{i_ins(6'h11, 3'd3, 7'd1),        32'hFF, 1'b0, 1'b1, 1'b0},
      '{i_ins(6'h12, 3'd2, 7'h0C),       32'h04, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd0, 7'd3),        32'h03, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd0, 7'd1),        32'h04, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h04, 3'd0, 3'd0, 3'd0),  32'h00, 1'b1, 1'b0, 1'b0}
    };

    vb = '{
      '{i_ins(6'h13, 3'd5, 7'h33),       32'h0033, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd5, 7'd1),        32'h0001, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h00, 3'd5, 3'd5, 3'd1),  32'h0000, 1'b1, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd3, 7'h7F),       32'h007F, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd3, 7'h7F),       32'h00FE, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h10, 3'd3, 7'h7F),       32'h017D, 1'b0, 1'b0, 1'b0},
      '{i_ins(6'h13, 3'd2, 7'd8),        32'h0008, 1'b0, 1'b0, 1'b0},
      '{r_ins(6'h05, 3'd3, 3'd2, 3'd1),  32'h7D00, 1'b0, 1'b1, 1'b0}
    };
    for (int k = 1; k <= 12; k++)
      vb.push_back('{i_ins(6'h10, 3'd0, 7'd1), 32'(k), 1'b0, 1'b0, 1'b0});

    rst_a = 1'b0; rst_b = 1'b0;
    instr_a = '0; instr_b = '0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;
    chk_reset_state(1'b0, "reset_a");
    chk_reset_state(1'b1, "reset_b");

    run_table(1'b0, va);

    // HALT: retires once, then refuses instructions until reset
    issue(1'b0, 16'hFC00, 1'b1, "halt");
    chk("halt not_illegal", {31'h0, g_ill}, 32'h0);
    chk("halt flags_kept", {30'h0, g_z, g_c}, {30'h0, 1'b1, 1'b0});
    bad = 0;
    valid_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      instr_a = 16'($urandom_range(0, 65535));
      @(negedge clk);
      if (rdy_a || !hlt_a || ret_a || dbg_a != 2'd3) bad++;
    end
    chk("halt hold_violations", 32'(bad), 32'h0);
    chk("halt cnt_frozen", {16'h0, cnt_a}, 32'(exp_cnt[0]));
    rst_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1; valid_a = 1'b0;
    exp_cnt[0] = 0;
    chk_reset_state(1'b0, "halt_reset");

    // reset while an instruction sits in EXEC
    @(negedge clk);
    instr_a = i_ins(6'h13, 3'd1, 7'd9); valid_a = 1'b1;
    @(posedge clk); #1 valid_a = 1'b0; rst_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ret_a || !rdy_a) bad++;
    end
    chk("exec_reset no_retire", 32'(bad), 32'h0);
    chk("exec_reset cnt", {16'h0, cnt_a}, 32'h0);
    issue(1'b0, i_ins(6'h10, 3'd1, 7'd0), 1'b0, "exec_reset readback");
    chk("exec_reset r1_zero", {30'h0, g_z, g_c, 8'h0} | g_res, {30'h0, 1'b1, 1'b0, 8'h0});

    run_table(1'b1, vb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
